// File: rtl/param_rom_stream_sequencer_if.sv
// rtl/param_rom_stream_sequencer_if.sv - ROM port and vector stream bundle for the parameter ROM sequencer
interface param_rom_stream_sequencer_if #(
  parameter int OUT_SIZE   = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0]         rom_addr;
  logic                          rom_ce;
  logic [OUT_WIDTH*OUT_SIZE-1:0] rom_q;
  logic [OUT_WIDTH-1:0]          data_out [OUT_SIZE];
  logic                          data_out_valid;
  logic                          data_out_ready;
  logic                          sweep_done;

  modport master (
    output rom_addr, rom_ce, data_out, data_out_valid, sweep_done,
    input  rom_q, data_out_ready
  );

  modport slave (
    input  rom_addr, rom_ce, data_out, data_out_valid, sweep_done,
    output rom_q, data_out_ready
  );
endinterface

// File: rtl/param_rom_stream_sequencer.sv
// rtl/param_rom_stream_sequencer.sv - drives a two-stage clock-enabled parameter ROM and streams its vectors
module param_rom_stream_sequencer #(
  parameter int OUT_SIZE   = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int OUT_DEPTH  = 8,
  parameter int REPEAT     = 1,
  parameter int ADDR_WIDTH = $clog2(OUT_DEPTH) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  param_rom_stream_sequencer_if.master bus
);
  localparam int REP_W = $clog2(REPEAT) + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(OUT_DEPTH - 1);
  localparam logic [REP_W-1:0]      REP_LAST  = REP_W'(REPEAT - 1);

  logic                  v0, v1;
  logic [ADDR_WIDTH-1:0] iss_addr, out_addr;
  logic [REP_W-1:0]      iss_rep, out_rep;
  logic                  ce, hs;

  // ROM stages only move when the output slot is free or being drained this cycle
  assign ce = !rst && !restart && (!v1 || bus.data_out_ready);
  assign hs = v1 && bus.data_out_ready;

  assign bus.rom_ce         = ce;
  assign bus.rom_addr       = iss_addr;
  assign bus.data_out_valid = v1;
  assign bus.sweep_done     = hs && (out_addr == ADDR_LAST) && (out_rep == REP_LAST);

  for (genvar j = 0; j < OUT_SIZE; j++) begin : g_slice
    assign bus.data_out[j] = bus.rom_q[OUT_WIDTH*j +: OUT_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      v0       <= 1'b0;
      v1       <= 1'b0;
      iss_addr <= '0;
      iss_rep  <= '0;
      out_addr <= '0;
      out_rep  <= '0;
    end else begin
      if (ce) begin
        v1 <= v0;
        v0 <= 1'b1;
        if (iss_rep == REP_LAST) begin
          iss_rep  <= '0;
          iss_addr <= (iss_addr == ADDR_LAST) ? '0 : iss_addr + 1'b1;
        end else begin
          iss_rep <= iss_rep + 1'b1;
        end
      end
      if (hs) begin
        if (out_rep == REP_LAST) begin
          out_rep  <= '0;
          out_addr <= (out_addr == ADDR_LAST) ? '0 : out_addr + 1'b1;
        end else begin
          out_rep <= out_rep + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_param_rom_stream_sequencer.sv
// tb/tb_param_rom_stream_sequencer.sv - directed bench for the parameter ROM stream sequencer
module tb_param_rom_stream_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [63:0] word_of(input int addr);
    return {4{16'(addr + 1)}};
  endfunction

  function automatic logic [31:0] pair_of(input int v);
    return {2{16'(v)}};
  endfunction

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic rs_a = 1'b0, rs_b = 1'b0, rs_c = 1'b0;
  logic ready_a = 1'b0, ready_b = 1'b0, ready_c = 1'b0;

  param_rom_stream_sequencer_if #(.OUT_SIZE(4), .OUT_WIDTH(16), .ADDR_WIDTH(3)) bus_a ();
  param_rom_stream_sequencer_if #(.OUT_SIZE(4), .OUT_WIDTH(16), .ADDR_WIDTH(3)) bus_b ();
  param_rom_stream_sequencer_if #(.OUT_SIZE(4), .OUT_WIDTH(16), .ADDR_WIDTH(1)) bus_c ();

  param_rom_stream_sequencer #(.OUT_SIZE(4), .OUT_WIDTH(16), .OUT_DEPTH(4), .REPEAT(1), .ADDR_WIDTH(3))
    dut_a (.clk(clk), .rst(rst_a), .restart(rs_a), .bus(bus_a));
  param_rom_stream_sequencer #(.OUT_SIZE(4), .OUT_WIDTH(16), .OUT_DEPTH(3), .REPEAT(2), .ADDR_WIDTH(3))
    dut_b (.clk(clk), .rst(rst_b), .restart(rs_b), .bus(bus_b));
  param_rom_stream_sequencer #(.OUT_SIZE(4), .OUT_WIDTH(16), .OUT_DEPTH(1), .REPEAT(1), .ADDR_WIDTH(1))
    dut_c (.clk(clk), .rst(rst_c), .restart(rs_c), .bus(bus_c));

  // Two-stage ROM models holding mem[i] = i+1 in every element
  logic [63:0] sa0, sa1, sb0, sb1, sc0, sc1;
  always @(posedge clk) if (bus_a.rom_ce) begin sa1 <= sa0; sa0 <= word_of(int'(bus_a.rom_addr)); end
  always @(posedge clk) if (bus_b.rom_ce) begin sb1 <= sb0; sb0 <= word_of(int'(bus_b.rom_addr)); end
  always @(posedge clk) if (bus_c.rom_ce) begin sc1 <= sc0; sc0 <= word_of(int'(bus_c.rom_addr)); end
  assign bus_a.rom_q = sa1;
  assign bus_b.rom_q = sb1;
  assign bus_c.rom_q = sc1;
  assign bus_a.data_out_ready = ready_a;
  assign bus_b.data_out_ready = ready_b;
  assign bus_c.data_out_ready = ready_c;

  logic [31:0] dv_a, dv_b, dv_c;
  assign dv_a = {bus_a.data_out[3], bus_a.data_out[0]};
  assign dv_b = {bus_b.data_out[3], bus_b.data_out[0]};
  assign dv_c = {bus_c.data_out[3], bus_c.data_out[0]};

  initial begin
    int beats;
    int v;
    int b;
    bit found;
    bit stall_prev;
    logic [31:0] pd;
    logic [2:0]  pa;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid_a", bus_a.data_out_valid, 0);
    chk("rst_ce_a",    bus_a.rom_ce, 0);
    chk("rst_addr_a",  bus_a.rom_addr, 0);
    chk("rst_sweep_a", bus_a.sweep_done, 0);
    chk("rst_valid_b", bus_b.data_out_valid, 0);
    chk("rst_ce_c",    bus_c.rom_ce, 0);

    // Fill and steady stream, depth 4, repeat 1
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); rst_a = 1'b0; ready_a = 1'b1; #1;
      chk("fill_addr", bus_a.rom_addr, k % 4);
      chk("fill_ce", bus_a.rom_ce, 1);
      chk("fill_valid", bus_a.data_out_valid, k >= 2);
      if (k >= 2) begin
        v = ((k - 2) % 4) + 1;
        chk("fill_data", dv_a, pair_of(v));
        chk("fill_sweep", bus_a.sweep_done, v == 4);
      end
    end

    // Repeat of 2 over depth 3
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); rst_b = 1'b0; ready_b = 1'b1; #1;
      chk("rep_addr", bus_b.rom_addr, (k / 2) % 3);
      chk("rep_valid", bus_b.data_out_valid, k >= 2);
      if (k >= 2) begin
        b = k - 2;
        chk("rep_data", dv_b, pair_of((b / 2) % 3 + 1));
        chk("rep_sweep", bus_b.sweep_done, (b % 6) == 5);
      end
    end

    // Reset mid-stream while stalled
    @(negedge clk); ready_b = 1'b0; #1;
    chk("rmid_ce_stall", bus_b.rom_ce, 0);
    @(negedge clk); #1;
    chk("rmid_valid_hold", bus_b.data_out_valid, 1);
    @(negedge clk); rst_b = 1'b1; rs_b = 1'b1; #1;
    chk("rmid_ce_in_rst", bus_b.rom_ce, 0);
    @(negedge clk); rst_b = 1'b0; rs_b = 1'b0; #1;
    chk("rmid_valid0", bus_b.data_out_valid, 0);
    chk("rmid_addr0", bus_b.rom_addr, 0);
    chk("rmid_ce0", bus_b.rom_ce, 1);
    @(negedge clk); #1;
    chk("rmid_valid1", bus_b.data_out_valid, 0);
    chk("rmid_addr1", bus_b.rom_addr, 0);
    @(negedge clk); #1;
    chk("rmid_valid2", bus_b.data_out_valid, 1);
    chk("rmid_data2", dv_b, pair_of(1));
    chk("rmid_addr2", bus_b.rom_addr, 1);
    chk("rmid_ce2", bus_b.rom_ce, 0);

    // Random backpressure on depth 4
    @(negedge clk); rst_a = 1'b1; @(negedge clk); rst_a = 1'b0;
    beats = 0; stall_prev = 1'b0; pd = '0; pa = '0;
    for (int cyc = 0; cyc < 1000 && beats < 100; cyc++) begin
      if (cyc > 0) @(negedge clk);
      ready_a = 1'($urandom_range(0, 1)); #1;
      if (stall_prev) begin
        chk("bp_hold_valid", bus_a.data_out_valid, 1);
        chk("bp_hold_data", dv_a, pd);
        chk("bp_hold_addr", bus_a.rom_addr, pa);
      end
      if (bus_a.data_out_valid && !ready_a) begin
        chk("bp_ce_low", bus_a.rom_ce, 0);
        stall_prev = 1'b1; pd = dv_a; pa = bus_a.rom_addr;
      end else begin
        stall_prev = 1'b0;
      end
      if (bus_a.data_out_valid && ready_a) begin
        v = (beats % 4) + 1;
        chk("bp_data", dv_a, pair_of(v));
        chk("bp_sweep", bus_a.sweep_done, v == 4);
        beats++;
      end
    end
    chk("bp_beats", beats, 100);

    // Restart during handshake of vector 2, then during the final beat
    @(negedge clk); rst_a = 1'b1; ready_a = 1'b1; @(negedge clk); rst_a = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      @(negedge clk); #1;
      if (bus_a.data_out_valid && dv_a == pair_of(3)) found = 1'b1;
    end
    chk("rs_found_v2", found, 1);
    rs_a = 1'b1; #1;
    chk("rs_ce", bus_a.rom_ce, 0);
    chk("rs_sweep_v2", bus_a.sweep_done, 0);
    @(negedge clk); rs_a = 1'b0; #1;
    chk("rs_valid0", bus_a.data_out_valid, 0);
    chk("rs_addr0", bus_a.rom_addr, 0);
    @(negedge clk); #1;
    chk("rs_valid1", bus_a.data_out_valid, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      chk("rs_beat_valid", bus_a.data_out_valid, 1);
      chk("rs_beat_data", dv_a, pair_of(k));
      if (k == 4) begin
        rs_a = 1'b1; #1;
        chk("rs_sweep_last", bus_a.sweep_done, 1);
      end
    end
    @(negedge clk); rs_a = 1'b0; #1;
    chk("rs_last_valid0", bus_a.data_out_valid, 0);

    // Depth 1, repeat 1
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); rst_c = 1'b0; ready_c = 1'b1; #1;
      chk("d1_addr", bus_c.rom_addr, 0);
      chk("d1_valid", bus_c.data_out_valid, k >= 2);
      if (k >= 2) begin
        chk("d1_data", dv_c, pair_of(1));
        chk("d1_sweep", bus_c.sweep_done, 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
